// File: rtl/seq_det_rr_scheduler_if.sv
// Request/result bundle for seq_det_rr_scheduler. Optional res_map port under
// SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN.
//
// Handshake: a requester raises req_valid[i] with req_data[i] stable and holds both
// until the scheduler pulses req_ready[i] (one cycle, one-hot); that pulse is the
// transfer. res_valid is a one-cycle strobe with no back-pressure.
interface seq_det_rr_scheduler_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(W + 1);

  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   hist_clr;
  logic             busy;
  logic             res_valid;
  logic [CW-1:0]    res_ch;
  logic [CNTW-1:0]  res_count;
`ifdef SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN
  logic [W-1:0]     res_map;

  modport master (output req_valid, req_data, hist_clr,
                  input  req_ready, busy, res_valid, res_ch, res_count, res_map);
  modport slave  (input  req_valid, req_data, hist_clr,
                  output req_ready, busy, res_valid, res_ch, res_count, res_map);
`else
  modport master (output req_valid, req_data, hist_clr,
                  input  req_ready, busy, res_valid, res_ch, res_count);
  modport slave  (input  req_valid, req_data, hist_clr,
                  output req_ready, busy, res_valid, res_ch, res_count);
`endif
endinterface

// File: rtl/seq_det_rr_scheduler.sv
// Round-robin time-shared serial pattern detector with per-channel saved history.
// Optional per-bit match map output under SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN.
module seq_det_rr_scheduler #(
  parameter int             NCH  = 4,
  parameter int             W    = 8,
  parameter int             PLEN = 3,
  parameter logic [PLEN-1:0] PAT = 3'b101
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_det_rr_scheduler_if.slave bus,
  output logic [1:0]            dbg_state
);
  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(W + 1);
  localparam int HW   = PLEN - 1;
  localparam int FW   = $clog2(PLEN);
  localparam int BW   = $clog2(W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, next_state;

  logic [CW-1:0]   rr_ptr, g, grant;
  logic            found;
  logic [W-1:0]    shreg;
  logic [HW-1:0]   hist;
  logic [FW-1:0]   fill;
  logic [BW-1:0]   bit_cnt;
  logic [CNTW-1:0] count;
  logic [PLEN-1:0] window;
  logic            match;
  logic [NCH-1:0]  req_ready_q;
  logic            res_valid_q;
  logic [CW-1:0]   res_ch_q;
  logic [CNTW-1:0] res_count_q;
  logic [HW-1:0]   hist_mem [NCH];
  logic [FW-1:0]   fill_mem [NCH];

  // First valid channel at or above rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + i) % NCH]) begin
        grant = CW'((int'(rr_ptr) + i) % NCH);
        found = 1'b1;
      end
    end
  end

  assign window = {hist, shreg[W-1]};
  assign match  = (window == PAT) && (fill == FW'(HW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (bit_cnt == BW'(W - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= '0;
      g           <= '0;
      shreg       <= '0;
      hist        <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      count       <= '0;
      req_ready_q <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_mem[i] <= '0;
        fill_mem[i] <= '0;
      end
    end else begin
      req_ready_q <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_count_q <= '0;
      case (state)
        IDLE: if (found) begin
          g           <= grant;
          req_ready_q <= NCH'(1) << grant;
        end
        LOAD: begin
          shreg   <= bus.req_data[g*W +: W];
          hist    <= hist_mem[g];
          fill    <= fill_mem[g];
          bit_cnt <= '0;
          count   <= '0;
        end
        SHIFT: begin
          hist    <= window[HW-1:0];
          fill    <= (fill == FW'(HW)) ? fill : fill + 1'b1;
          shreg   <= {shreg[W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          count   <= count + CNTW'(match);
          // Result registers load on the last bit so they are valid in DONE.
          if (bit_cnt == BW'(W - 1)) begin
            res_valid_q <= 1'b1;
            res_ch_q    <= g;
            res_count_q <= count + CNTW'(match);
          end
        end
        DONE: rr_ptr <= (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
        default: ;
      endcase
      // A clear on the granted channel in DONE beats the write-back.
      for (int i = 0; i < NCH; i++) begin
        if (bus.hist_clr[i]) begin
          hist_mem[i] <= '0;
          fill_mem[i] <= '0;
        end else if (state == DONE && g == CW'(i)) begin
          hist_mem[i] <= hist;
          fill_mem[i] <= fill;
        end
      end
    end
  end

`ifdef SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN
  logic [W-1:0] map_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     map_q <= '0;
    else if (state == LOAD)       map_q <= '0;
    else if (state == SHIFT && match) map_q[BW'(W - 1) - bit_cnt] <= 1'b1;
  end
  assign bus.res_map = map_q;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_count = res_count_q;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_seq_det_rr_scheduler.sv
// Directed + randomized bench for seq_det_rr_scheduler against a bit-stream
// reference model kept per channel.
module tb_seq_det_rr_scheduler;
  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int PLEN = 3;
  localparam logic [PLEN-1:0] PAT = 3'b101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_det_rr_scheduler_if #(.NCH(NCH), .W(W)) bus ();
  logic [1:0] dbg_state;

  seq_det_rr_scheduler #(.NCH(NCH), .W(W), .PLEN(PLEN), .PAT(PAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  int          rr_model;
  logic [31:0] recent [NCH];
  int          seen   [NCH];

  // scoreboard
  logic [W-1:0] exp_q [$];
  int           ch_q  [$];
  logic [W-1:0] map_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    rr_model = 0;
    for (int i = 0; i < NCH; i++) begin
      recent[i] = '0;
      seen[i]   = 0;
    end
  endfunction

  // Append the word's bits MSB-first to the channel's stream; a match is the
  // last PLEN bits equalling PAT once PLEN bits exist since the last clear.
  function automatic void model_word(input int ch, input logic [W-1:0] word,
                                     output int cnt, output logic [W-1:0] map);
    cnt = 0;
    map = '0;
    for (int k = 0; k < W; k++) begin
      recent[ch] = {recent[ch][30:0], word[W-1-k]};
      seen[ch]++;
      if (seen[ch] >= PLEN && recent[ch][PLEN-1:0] == PAT) begin
        cnt++;
        map[W-1-k] = 1'b1;
      end
    end
  endfunction

  function automatic int pick(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++)
      if (v[(rr_model + i) % NCH]) return (rr_model + i) % NCH;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " busy"},      32'(bus.busy),      32'd0);
    check({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, " res_ch"},    32'(bus.res_ch),    32'd0);
    check({tag, " res_count"}, 32'(bus.res_count), 32'd0);
`ifdef SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN
    check({tag, " res_map"},   32'(bus.res_map),   32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.hist_clr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic clear_ch(input int ch);
    bus.req_valid = '0;
    bus.hist_clr[ch] = 1'b1;
    @(posedge clk);
    #1;
    bus.hist_clr = '0;
    recent[ch] = '0;
    seen[ch]   = 0;
  endtask

  task automatic send(input string tag, input logic [NCH-1:0] vmask,
                      input logic [NCH*W-1:0] data, input bit hold);
    int g, cnt, lat;
    logic [W-1:0] map;
    bit got;
    g = pick(vmask);
    model_word(g, data[g*W +: W], cnt, map);
    exp_q.push_back(W'(cnt));
    ch_q.push_back(g);
    map_q.push_back(map);
    bus.req_valid = vmask;
    bus.req_data  = data;
    got = 1'b0;
    for (int c = 0; c < W + 8 && !got; c++) begin
      @(posedge clk);
      #1;
      if (bus.req_ready != '0) got = 1'b1;
    end
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1 << g);
    check({tag, " busy"},  32'(bus.busy), 32'd1);
    if (!hold) bus.req_valid[g] = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < W + 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.res_valid) got = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(W + 1));
    check({tag, " res_ch"},    32'(bus.res_ch),    32'(ch_q.pop_front()));
    check({tag, " res_count"}, 32'(bus.res_count), 32'(exp_q.pop_front()));
`ifdef SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN
    check({tag, " res_map"},   32'(bus.res_map),   32'(map_q.pop_front()));
`else
    void'(map_q.pop_front());
`endif
    rr_model = (g + 1) % NCH;
    @(posedge clk);
    #1;
    check({tag, " strobe_len"}, 32'(bus.res_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic [NCH*W-1:0] d;

    do_reset();

    // ch0 alternating pattern
    send("alt", 4'b0001, {24'h0, 8'b1010_1010}, 1'b0);

    // match across a word boundary
    send("xb_a", 4'b0001, {24'h0, 8'h01}, 1'b0);
    send("xb_b", 4'b0001, {24'h0, 8'h40}, 1'b0);

    // clear between words breaks the boundary match
    send("clr_a", 4'b0001, {24'h0, 8'h01}, 1'b0);
    clear_ch(0);
    repeat (2) @(posedge clk);
    #1;
    send("clr_b", 4'b0001, {24'h0, 8'h40}, 1'b0);

    // continuous valid on all channels: order 0,1,2,3,0, histories isolated
    do_reset();
    d = {8'($urandom), 8'($urandom), 8'hFF, 8'h01};
    send("rr0", 4'b1111, d, 1'b1);
    send("rr1", 4'b1111, d, 1'b1);
    send("rr2", 4'b1111, d, 1'b1);
    send("rr3", 4'b1111, d, 1'b1);
    d[7:0] = 8'h40;
    send("rr4", 4'b1111, d, 1'b1);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);

    // reset during the 4th SHIFT cycle drops the word and all history
    send("pre_rst", 4'b0001, {24'h0, 8'h01}, 1'b0);
    bus.req_valid = 4'b0001;
    bus.req_data  = {24'h0, 8'h55};
    pulses = 0;
    for (int c = 0; c < W + 8 && bus.req_ready == '0; c++) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < W + 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) pulses++;
    end
    check("mid_rst no_result", 32'(pulses), 32'd0);
    send("post_rst", 4'b0001, {24'h0, 8'h40}, 1'b0);

    // rr pointer at 3, only ch2 requesting: grant wraps to ch2
    do_reset();
    send("wrap_a", 4'b0100, {8'h00, 8'($urandom), 16'h0}, 1'b0);
    send("wrap_b", 4'b0100, {8'h00, 8'($urandom), 16'h0}, 1'b0);

    // randomized traffic with occasional clears
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) clear_ch($urandom_range(0, NCH - 1));
      send("rand", NCH'($urandom_range(1, 15)), $urandom, 1'b0);
    end
    bus.req_valid = '0;
    repeat (3) @(posedge clk);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/seq_det_rr_scheduler.md
Name: seq_det_rr_scheduler

Overview:
Time-shares one serial pattern-match engine among NCH requesters. Each requester hands over a W-bit word through a valid/ready handshake. The block grants requesters round-robin and shifts the granted word MSB-first through the match engine, one bit per clock. Match history is saved per channel, so each channel's stream is detected continuously across words, with overlapping matches counted. It sits between the parallel capture logic and the status/interrupt logic of the sequence-detector subsystem.

Parameters:
NCH, 4, number of requesting channels (2..8)
W, 8, bits per word (2..32)
PLEN, 3, pattern length in bits (2..8, PLEN-1 <= W)
PAT, 3'b101, pattern; PAT[PLEN-1] is the oldest bit

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NCH  channel i has a word pending
req_data  input  NCH*W  word for channel i in bits [i*W +: W]
req_ready  output  NCH  one-cycle accept pulse, one-hot
hist_clr  input  NCH  synchronous clear of channel i's saved history
busy  output  1  high in any state other than IDLE
res_valid  output  1  one-cycle result strobe
res_ch  output  clog2(NCH)  channel of the result
res_count  output  clog2(W+1)  matches found in the word

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; all outputs 0; rr pointer=0; every channel's history and fill cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid: grant g = first valid channel searching from the rr pointer upward, with wrap. Register g. Go to LOAD.
- LOAD (1 cycle): req_ready[g]=1; capture req_data[g] into the shift register; load the working history and fill from channel g; bit counter=0; count=0. Go to SHIFT.
- If req_valid[g] has dropped by LOAD, the word is still captured. Requesters must hold valid and data until ready.
- SHIFT (exactly W cycles): b = current MSB; window = {history[PLEN-2:0], b}.
- A match is counted when window==PAT and fill==PLEN-1.
- Each SHIFT cycle then: history shifts left taking b; fill saturates at PLEN-1; data shifts left.
- After W bits, go to DONE.
- DONE (1 cycle): res_valid=1, res_ch=g, res_count=count. Write back history and fill to channel g. rr pointer = g+1, wrapping to 0. Go to IDLE.
- Timing: req_ready is asserted 1 cycle after IDLE samples valid. res_valid is asserted W+1 cycles after req_ready. Minimum spacing between grants is W+3 cycles.
- hist_clr[i] clears channel i's history and fill at the clock edge.
- If hist_clr[g] is high in the DONE cycle, the clear wins over the write-back. A clear asserted during SHIFT on the active channel does not affect the word in flight.
- Fill starts at 0 after reset or clear, so no match is reported until PLEN-1 real bits have been seen.
- res_count cannot overflow: its maximum value is W.
- Outputs res_valid, res_ch, res_count and req_ready are registered. busy is decoded from the state.
- Reset mid-operation: the word is dropped with no res_valid, and all histories are cleared.

Optional Feature:
- Macro SEQ_DET_RR_SCHEDULER_MATCH_MAP_EN.
- Defined: adds output port res_map (W bits), valid with res_valid. Bit W-1-k is 1 if shift step k (k=0 is the MSB) completed a match. res_map is 0 at reset and cleared in LOAD.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Fresh reset; ch0 sends 8'b1010_1010 -> req_ready[0] pulse; res_valid 9 cycles later with res_ch=0, res_count=3; res_map=8'b0010_1010.
- ch0 sends 8'h01 (count 0), then 8'h40 -> second result res_count=1, from the match across the word boundary.
- ch0 sends 8'h01; hist_clr[0] pulse; ch0 sends 8'h40 -> res_count=0.
- All four channels hold valid continuously -> grant order 0,1,2,3,0. Interleave ch1 words 8'hFF while ch0 carries 8'h01 then 8'h40 -> ch0 still counts 1 (histories isolated per channel).
- rst low during the 4th SHIFT cycle -> no res_valid; all outputs 0. After release, ch0 sends 8'h40 -> res_count=0.
- Only ch2 valid while the rr pointer=3 -> grant wraps to ch2; no req_ready pulse to any other channel.
